// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction-cache read bus between fetch unit and cache
//
// Purpose: groups the instruction-cache read handshake into one bundle.
// Signals:
//   cacheReadRequest  fetch -> cache  read requested, cacheReadPtr valid
//   cacheReadPtr      fetch -> cache  word address being read
//   cacheReadValue    cache -> fetch  returned instruction word
//   cacheReadSuccess  cache -> fetch  response valid this cycle
//   cacheBusy         cache -> fetch  per-block refill-in-progress flags
// Modports: master (fetch unit side), slave (cache side).
interface instruction_fetch_unit_if #(
  parameter int NUMBER_OF_BLOCKS_IN_CACHE_LOG = 2
);
  logic                                        cacheReadRequest;
  logic [31:0]                                 cacheReadPtr;
  logic [31:0]                                 cacheReadValue;
  logic                                        cacheReadSuccess;
  logic [(2**NUMBER_OF_BLOCKS_IN_CACHE_LOG)-1:0] cacheBusy;

  modport master (
    output cacheReadRequest,
    output cacheReadPtr,
    input  cacheReadValue,
    input  cacheReadSuccess,
    input  cacheBusy
  );

  modport slave (
    input  cacheReadRequest,
    input  cacheReadPtr,
    output cacheReadValue,
    output cacheReadSuccess,
    output cacheBusy
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, cache read initiator and instruction buffer
//
// Purpose: owns the PC, issues one outstanding word read at a time to the
// instruction cache, buffers returned words in an in-order FIFO for decode,
// and handles redirects, miss-stall counting and fetch timeouts.
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   cache             instruction-cache read bus (master side)
//   redirectValid/Target  branch/jump redirect strobe and word address
//   instrValid/instr/instrPc/instrReady  FIFO head towards decode
//   missCycles        saturating count of WAIT cycles on a busy block
//   fetchError        sticky timeout flag, cleared only by reset
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC                      = 32'h0000_0000,
  parameter int          FIFO_DEPTH                    = 2,
  parameter int          BLOCK_SIZE_LOG                = 4,
  parameter int          NUMBER_OF_BLOCKS_IN_CACHE_LOG = 2,
  parameter int          TIMEOUT_CYCLES                = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master cache,
  input  logic                     redirectValid,
  input  logic [31:0]              redirectTarget,
  output logic                     instrValid,
  output logic [31:0]              instr,
  output logic [31:0]              instrPc,
  input  logic                     instrReady,
  output logic [15:0]              missCycles,
  output logic                     fetchError
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pend_q, pend_d;
  logic [WC_W-1:0]   wait_cnt_q;
  logic [15:0]       miss_q;

  logic [31:0]       fifo_pc   [FIFO_DEPTH];
  logic [31:0]       fifo_word [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              push, pop, flush, issue, tick;
  logic              success, timeout_hit, busy_hit;
  logic [CNT_W-1:0]  cnt_after_pop;

  // Success is only meaningful while a request is on the bus.
  assign success     = cache.cacheReadSuccess &&
                       ((state_q == S_WAIT) || (state_q == S_DRAIN));
  assign pop         = (count_q != '0) && instrReady;
  assign cnt_after_pop = count_q - CNT_W'(pop);
  // The counter would reach TIMEOUT_CYCLES on this edge.
  assign timeout_hit = (wait_cnt_q == WC_W'(TIMEOUT_CYCLES - 1));
  assign busy_hit    = cache.cacheBusy[pc_q[BLOCK_SIZE_LOG +: NUMBER_OF_BLOCKS_IN_CACHE_LOG]];

  // pc_q is always the address on the bus: in DRAIN it still holds the
  // abandoned address while the redirect waits in pend_q.
  assign cache.cacheReadRequest = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign cache.cacheReadPtr     = pc_q;

  assign instrValid = (count_q != '0);
  assign instr      = fifo_word[rd_ptr_q];
  assign instrPc    = fifo_pc[rd_ptr_q];
  assign missCycles = miss_q;
  assign fetchError = (state_q == S_ERROR);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    push    = 1'b0;
    flush   = 1'b0;
    issue   = 1'b0;
    tick    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (redirectValid) begin
          flush = 1'b1;
          pc_d  = redirectTarget;
        end else if (cnt_after_pop < CNT_W'(FIFO_DEPTH)) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (success) begin
          if (redirectValid) begin
            flush = 1'b1;
            pc_d  = redirectTarget;
            issue = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = pc_q + 32'd1;
            if ((cnt_after_pop + CNT_W'(1)) < CNT_W'(FIFO_DEPTH)) begin
              issue = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          tick = 1'b1;
          if (redirectValid) begin
            flush   = 1'b1;
            pend_d  = redirectTarget;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (success) begin
          flush   = redirectValid;
          pc_d    = redirectValid ? redirectTarget : pend_q;
          issue   = 1'b1;
          state_d = S_WAIT;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          tick = 1'b1;
          if (redirectValid) begin
            flush  = 1'b1;
            pend_d = redirectTarget;
          end
        end
      end
      default: begin
        // ERROR: only reset leaves this state.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      wait_cnt_q <= '0;
      miss_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      if (issue) begin
        wait_cnt_q <= '0;
      end else if (tick) begin
        wait_cnt_q <= wait_cnt_q + WC_W'(1);
      end
      if ((state_q == S_WAIT) && busy_hit && (miss_q != 16'hFFFF)) begin
        miss_q <= miss_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_word[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr_q]   <= pc_q;
        fifo_word[wr_ptr_q] <= cache.cacheReadValue;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-cache read interface. It owns the program counter and drives word addresses to the instruction cache, with one request outstanding at a time. Returned words are buffered in a small in-order FIFO that feeds decode. It also handles branch redirects, miss-stall accounting and fetch timeouts.

Parameters:
RESET_PC, 32'h0000_0000, word address fetched first after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)
BLOCK_SIZE_LOG, 4, offset bits of a word address
NUMBER_OF_BLOCKS_IN_CACHE_LOG, 2, index bits; cacheBusy width = 2**this
TIMEOUT_CYCLES, 255, maximum cycles in WAIT/DRAIN before an error is raised

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
cacheReadRequest  out  1  cacheReadPtr is valid and a read is requested
cacheReadPtr  out  32  word address to the cache
cacheReadValue  in  32  returned instruction word
cacheReadSuccess  in  1  response valid this cycle, for the held pointer
cacheBusy  in  2**NUMBER_OF_BLOCKS_IN_CACHE_LOG  per-block refill-in-progress flags
redirectValid  in  1  branch/jump redirect strobe
redirectTarget  in  32  redirect word address
instrValid  out  1  FIFO head valid
instr  out  32  FIFO head instruction
instrPc  out  32  word address of the FIFO head
instrReady  in  1  consumer pops the head when instrValid && instrReady
missCycles  out  16  saturating count of WAIT cycles with the addressed block busy
fetchError  out  1  sticky timeout flag

Behaviour:
- Reset (reset==0 at posedge):
  - pc=RESET_PC, state=IDLE, FIFO empty, waitCounter=0, pendingTarget=0.
  - Outputs: cacheReadRequest=0, cacheReadPtr=RESET_PC, instrValid=0, instr=0, instrPc=0, missCycles=0, fetchError=0.
  - Reset overrides all other inputs, including mid-request; any in-flight response is ignored.
- Addresses are word addresses: sequential fetch increments by 1, wrapping 32'hFFFF_FFFF -> 0.
- Handshake:
  - cacheReadPtr is stable whenever cacheReadRequest=1, until a posedge that samples cacheReadSuccess=1.
  - cacheReadSuccess while cacheReadRequest=0 is ignored.
- Credit rule: a request is issued only if (FIFO count after this cycle's pop) < FIFO_DEPTH.
- State IDLE (cacheReadRequest=0):
  - redirectValid: flush FIFO, pc=redirectTarget, stay IDLE.
  - Otherwise, if credit available: cacheReadRequest=1, cacheReadPtr=pc, go to WAIT.
- State WAIT (cacheReadRequest=1):
  - Success and no redirect:
    - Push {pc, cacheReadValue}; pc=pc+1.
    - If credit remains after the push, issue pc+1 back-to-back (stay WAIT).
    - Otherwise drop the request and go to IDLE.
  - Success and redirect in the same cycle: discard the word, flush FIFO, pc=redirectTarget, issue the target, stay WAIT.
  - Redirect without success: flush FIFO, pendingTarget=redirectTarget, go to DRAIN.
  - Each WAIT cycle where cacheBusy[cacheReadPtr[BLOCK_SIZE_LOG +: NUMBER_OF_BLOCKS_IN_CACHE_LOG]]==1: missCycles+=1, saturating at 16'hFFFF.
- State DRAIN:
  - Hold the old pointer and request.
  - A further redirect overwrites pendingTarget.
  - On success: discard the word, pc=pendingTarget, issue the target, go to WAIT.
  - A redirect in the same cycle as that success uses the new target.
- Timeout:
  - waitCounter resets on every issue and increments each cycle in WAIT/DRAIN.
  - When it reaches TIMEOUT_CYCLES without success: go to ERROR, cacheReadRequest=0, fetchError=1.
  - ERROR is left only by reset; redirects are ignored in ERROR.
- FIFO:
  - Push and pop in the same cycle leave count unchanged.
  - Flush takes priority over pop and push in the same cycle.
  - instrValid = (count != 0); instr/instrPc are the head entry, registered.
- Latency:
  - Request is high 1 cycle after reset deassertion.
  - A word returned at edge N appears on instr after edge N (instrValid=1 in cycle N+1).
  - Redirect at edge N puts redirectTarget on cacheReadPtr after edge N, provided no request is outstanding or success is sampled at N.
- Throughput: 1 instruction/cycle when the cache responds with success on the cycle after each request and instrReady=1.

Test Plan:
1. Reset release with RESET_PC=0x100; cache hits every cycle; instrReady=1 -> instrPc sequence 0x100,0x101,0x102,0x103 on consecutive cycles, instr matches memory.
2. instrReady=0 with FIFO_DEPTH=2 -> exactly 2 entries fetched, then cacheReadRequest=0. Raise instrReady -> request resumes at pc 0x102 with no duplicate or lost PC.
3. Miss: cacheBusy[1]=1 for 20 cycles while ptr=0x010, then success -> missCycles=20, instrPc=0x010.
4. Redirect to 0x400 while waiting on 0x020 -> FIFO flushed; the 0x020 response is discarded; next request is 0x400 and the first instrPc is 0x400. A redirect coincident with success behaves the same.
5. No response for 255 cycles -> fetchError=1, cacheReadRequest=0. A later redirect has no effect; reset (reset=0 for one edge) clears fetchError and restarts at RESET_PC.
6. pc=32'hFFFF_FFFF with a hit -> next request address 0x0000_0000. A reset asserted mid-WAIT drops the request on the next cycle.
